spi_mem_loader: RTL and testbench

- SPI slave that writes the on-chip parameter memory (weights/delays) from an external host.
- Also reads it back over MISO.
- Converts serial frames into single-cycle write strobes on the memory's data/address/write-enable port, with burst auto-increment.
- Sits between the chip's SPI pins and the parameter memory; the SNN core reads that memory in parallel.

---
 rtl/spi_mem_loader_pkg.sv | 19 +
 rtl/spi_mem_loader_if.sv | 30 +++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_mem_loader.sv | 175 +++++++++++++++++
 tb/tb_spi_mem_loader.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_mem_loader_pkg.sv
// Shared constants and FSM encoding for the SPI parameter-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_mem_loader_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_mem_loader_if.sv
// SPI pins plus parameter-memory port of the loader, bundled as one interface.
// Latency: n/a (wires only).
// Backpressure: none; SPI is host-timed and the memory accepts every strobe.
// slave modport: loader side (SPI slave, memory master).
// master modport: environment side (SPI host pins and the memory itself).
interface spi_mem_loader_if #(
  parameter int N  = 8,
  parameter int AW = 4
);
  logic          sclk;
  logic          cs_n;
  logic          mosi;
  logic          miso;
  logic [N-1:0]  mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_we;
  logic          busy;
  logic          err;

  modport slave (
    input  sclk, cs_n, mosi, mem_rdata,
    output miso, mem_addr, mem_wdata, mem_we, busy, err
  );

  modport master (
    output sclk, cs_n, mosi, mem_rdata,
    input  miso, mem_addr, mem_wdata, mem_we, busy, err
  );
endinterface

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer with rise/fall pulse detection in the clk domain.
// Latency: an input edge yields a one-clk pulse 2 clk after capture.
// Backpressure: none.
// Ports: clk, reset (async active-low), din (async), rise/fall (one-clk pulses).
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave that bursts writes into / reads back from the parameter memory.
// Latency: last sclk rise of a data byte to mem_we high is 4 clk.
// Backpressure: none; host-timed, needs f_clk >= 4*f_sclk.
// Ports: clk, reset (async active-low), bus (slave modport: SPI pins,
//        memory addr/wdata/we/rdata, busy and sticky err).
module spi_mem_loader
  import spi_mem_loader_pkg::*;
#(
  parameter int M  = 10,
  parameter int N  = 8,
  parameter int AW = $clog2(M)
) (
  input  logic             clk,
  input  logic             reset,
  spi_mem_loader_if.slave  bus
);

  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_rise;
  logic              cs_fall;
  logic              mosi_meta;
  logic              mosi_s;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_sh;
  logic [BYTE_W-1:0] rx_byte;
  logic [BYTE_W-1:0] tx_sh;
  logic              is_read;
  logic              we_pend;
  logic              ld_pend;
  logic              byte_done;
  logic              cmd_ok;
  logic              addr_ok;
  logic              rd_active;

  logic [AW-1:0]     mem_addr_q;
  logic [N-1:0]      mem_wdata_q;
  logic              mem_we_q;
  logic              err_q;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // cs_n idles high, so its synchronizer resets high to avoid a fake frame start.
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // mosi shares the sclk synchronizer depth, so it is aligned with sclk_rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= bus.mosi;
      mosi_s    <= mosi_meta;
    end
  end

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(M - 1)) ? '0 : a + AW'(1);
  endfunction

  assign rx_byte   = {rx_sh, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);
  assign cmd_ok    = (rx_byte == CMD_WRITE) || (rx_byte == CMD_READ);
  assign addr_ok   = rx_byte < BYTE_W'(M);
  assign rd_active = (state == ST_DATA) && is_read;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (cs_fall)   state_nxt = ST_CMD;
        ST_CMD:  if (byte_done) state_nxt = cmd_ok  ? ST_ADDR : ST_IGNORE;
        ST_ADDR: if (byte_done) state_nxt = addr_ok ? ST_DATA : ST_IGNORE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      is_read     <= 1'b0;
      we_pend     <= 1'b0;
      ld_pend     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      // Write strobe trails byte completion by one clk; address advances after it.
      mem_we_q <= we_pend;
      we_pend  <= 1'b0;
      ld_pend  <= 1'b0;
      if (mem_we_q) mem_addr_q <= addr_inc(mem_addr_q);

      if (state == ST_IDLE && cs_fall) begin
        bit_cnt <= '0;
        err_q   <= 1'b0;
      end

      if (sclk_rise && state != ST_IDLE) begin
        rx_sh   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      // Reload uses mem_rdata one clk after mem_addr moves. The falling edge
      // right after a byte boundary (bit_cnt == 0) must not shift, or the
      // freshly loaded MSB would be lost before the host samples it.
      if (ld_pend) begin
        tx_sh <= BYTE_W'(bus.mem_rdata);
      end else if (sclk_fall && rd_active && bit_cnt != 3'd0) begin
        tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
      end

      if (byte_done && !cs_rise) begin
        unique case (state)
          ST_CMD: begin
            is_read <= (rx_byte == CMD_READ);
            if (!cmd_ok) err_q <= 1'b1;
          end
          ST_ADDR: begin
            if (addr_ok) begin
              mem_addr_q <= rx_byte[AW-1:0];
              ld_pend    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          ST_DATA: begin
            if (is_read) begin
              mem_addr_q <= addr_inc(mem_addr_q);
              ld_pend    <= 1'b1;
            end else begin
              mem_wdata_q <= rx_byte[N-1:0];
              we_pend     <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.miso      = rd_active ? tx_sh[BYTE_W-1] : 1'b0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
`timescale 1ns/1ps
module tb_spi_mem_loader;

  localparam int M    = 10;
  localparam int N    = 8;
  localparam int AW   = 4;
  localparam int HALF = 6;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_mem_loader_if #(.N(N), .AW(AW)) bus();

  spi_mem_loader #(.M(M), .N(N), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory device: combinational read, written only by DUT strobes.
  logic [N-1:0] mem [16] = '{default: '0};
  assign bus.mem_rdata = mem[bus.mem_addr];

  // Reference memory image, updated from frame contents, not from the DUT.
  logic [N-1:0] exp_mem [M];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wa[$];
  int wd[$];
  int wc[$];
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa.push_back(int'(bus.mem_addr));
      wd.push_back(int'(bus.mem_wdata));
      wc.push_back(cyc);
      mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 host: mosi set while sclk low, miso sampled just before the rise.
  task automatic spi_byte(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output int rise_cyc);
    rx = '0;
    rise_cyc = 0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      clk_wait(HALF);
      rx = {rx[6:0], bus.miso};
      bus.sclk = 1'b1;
      rise_cyc = cyc;
      clk_wait(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  logic [7:0] fd [8];

  // One frame: cmd, addr, nd full data bytes from fd[], then pbits of a partial byte.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                           input int nd, input int pbits);
    logic [7:0] rx;
    int         rc;
    int         rise_at [8];
    logic [7:0] got [8];
    bit         wr;
    bit         rd;
    bit         exp_err;
    wr = (cmd == 8'h01) && (int'(addr) < M);
    rd = (cmd == 8'h02) && (int'(addr) < M);
    exp_err = !(((cmd == 8'h01) || (cmd == 8'h02)) && (int'(addr) < M));
    wa.delete(); wd.delete(); wc.delete();

    bus.cs_n = 1'b0;
    clk_wait(8);
    check("busy_start", 32'(bus.busy), 32'd1);
    check("err_clear",  32'(bus.err),  32'd0);
    spi_byte(cmd, 8, rx, rc);
    check("miso_cmd", 32'(rx), 32'd0);
    spi_byte(addr, 8, rx, rc);
    check("miso_addr", 32'(rx), 32'd0);
    for (int i = 0; i < nd; i++) spi_byte(fd[i], 8, got[i], rise_at[i]);
    if (pbits > 0) spi_byte(8'hFF, pbits, rx, rc);
    clk_wait(HALF);
    bus.cs_n = 1'b1;
    clk_wait(10);

    check("busy_end", 32'(bus.busy), 32'd0);
    check("err",      32'(bus.err),  32'(exp_err));
    check("we_count", 32'(wa.size()), wr ? 32'(nd) : 32'd0);
    for (int i = 0; i < nd; i++) begin
      int a;
      a = (int'(addr) + i) % M;
      if (rd) check("rd_byte", 32'(got[i]), 32'(exp_mem[a]));
      else    check("miso_zero", 32'(got[i]), 32'd0);
      if (wr) begin
        exp_mem[a] = fd[i][N-1:0];
        if (i < wa.size()) begin
          check("we_addr", 32'(wa[i]), 32'(a));
          check("we_data", 32'(wd[i]), 32'(fd[i][N-1:0]));
          check("we_latency", 32'(wc[i] - rise_at[i]), 32'd4);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] rx;
    int         rc;
    int         r;
    logic [7:0] cmd;
    logic [7:0] addr;
    int         nd;

    for (int i = 0; i < M; i++) exp_mem[i] = '0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    reset    = 1'b0;
    clk_wait(3);
    check("rst_we",    32'(bus.mem_we),    32'd0);
    check("rst_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_miso",  32'(bus.miso),      32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_err",   32'(bus.err),       32'd0);
    reset = 1'b1;
    clk_wait(5);

    // Burst write, then a burst that wraps from M-1 to 0.
    fd[0] = 8'hAA; fd[1] = 8'h55;
    run_frame(8'h01, 8'h03, 2, 0);
    fd[0] = 8'h11; fd[1] = 8'h22;
    run_frame(8'h01, 8'h09, 2, 0);

    // Seed [2]/[3] through the DUT, then read them back.
    fd[0] = 8'h3C; fd[1] = 8'hC3;
    run_frame(8'h01, 8'h02, 2, 0);
    fd[0] = 8'h00; fd[1] = 8'h00;
    run_frame(8'h02, 8'h02, 2, 0);

    // Bad command, bad address, and a valid frame that must clear err.
    run_frame(8'h7F, 8'h0A, 0, 0);
    fd[0] = 8'h66;
    run_frame(8'h01, 8'h05, 1, 0);
    fd[0] = 8'h33;
    run_frame(8'h01, 8'h0A, 1, 0);

    // Frame cut after 5 bits of a data byte, then a clean frame.
    run_frame(8'h01, 8'h04, 0, 5);
    fd[0] = 8'h77;
    run_frame(8'h01, 8'h04, 1, 0);

    // Reset in the middle of byte2 of a write.
    wa.delete(); wd.delete(); wc.delete();
    bus.cs_n = 1'b0;
    clk_wait(8);
    spi_byte(8'h01, 8, rx, rc);
    spi_byte(8'h02, 8, rx, rc);
    spi_byte(8'h5A, 4, rx, rc);
    reset = 1'b0;
    #1;
    check("mid_rst_we",    32'(bus.mem_we),    32'd0);
    check("mid_rst_addr",  32'(bus.mem_addr),  32'd0);
    check("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("mid_rst_busy",  32'(bus.busy),      32'd0);
    check("mid_rst_err",   32'(bus.err),       32'd0);
    check("mid_rst_miso",  32'(bus.miso),      32'd0);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    clk_wait(5);
    reset = 1'b1;
    clk_wait(10);
    check("mid_rst_no_we", 32'(wa.size()), 32'd0);
    fd[0] = 8'h5A;
    run_frame(8'h01, 8'h02, 1, 0);
    fd[0] = 8'h00;
    run_frame(8'h02, 8'h02, 1, 0);

    // Randomized frames against the reference memory image.
    for (int f = 0; f < 24; f++) begin
      r    = int'($urandom_range(0, 9));
      cmd  = (r < 5) ? 8'h01 : (r < 9) ? 8'h02 : 8'($urandom_range(3, 255));
      addr = 8'($urandom_range(0, M + 1));
      nd   = int'($urandom_range(1, 4));
      for (int i = 0; i < nd; i++) fd[i] = 8'($urandom);
      run_frame(cmd, addr, nd, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
